// File: rtl/pcs_tx_gb_seq.sv
`default_nettype none
// ============================================================================
// Module      : pcs_tx_gb_seq
// Description : 64b/66b transmit sequencer. Generates the part index, sync
//               header strobe and gearbox shift/flush for the encoder,
//               scrambler and 32-bit gearbox. It also throttles the MAC to
//               one stall in every 33 cycles, so 66-bit blocks fit a
//               32-bit-per-cycle PMA stream.
//               Optional build macro PCS_TX_GB_SEQ_CHECK_EN adds a sticky
//               error flag for beats presented while not ready.
// Revision    : 1.0 - initial release
// ============================================================================
module pcs_tx_gb_seq #(
    parameter int XGMII_DATA_W = 32,
    parameter int BLOCK_W      = 64,
    parameter int CNT_N        = BLOCK_W / XGMII_DATA_W,
    parameter int CNT_W        = $clog2(CNT_N),
    parameter int SEQ_N        = 33,
    parameter int SEQ_W        = $clog2(SEQ_N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             beat_v_i,
    output logic             mac_ready_o,
    output logic [CNT_W-1:0] part_o,
    output logic             hdr_v_o,
    output logic [SEQ_W-1:0] gb_seq_o,
    output logic [SEQ_W-1:0] gb_shift_o,
    output logic             gb_flush_o,
    output logic             err_o
);

    // Last sequence position is the flush (stall) slot.
    localparam logic [SEQ_W-1:0] c_SEQ_LAST  = SEQ_W'(SEQ_N - 1);
    localparam logic [CNT_W-1:0] c_PART_LAST = CNT_W'(CNT_N - 1);

    logic             r_en_q;
    logic [SEQ_W-1:0] r_seq;
    logic [CNT_W-1:0] r_part;

    logic             w_at_flush;
    logic             w_ready;
    logic [SEQ_W-1:0] w_seq_p1;

    // Flush detection uses exact equality; seq never exceeds the last slot.
    assign w_at_flush = (r_seq == c_SEQ_LAST);
    assign w_ready    = r_en_q && !w_at_flush;
    assign w_seq_p1   = r_seq + 1'b1;

    assign mac_ready_o = w_ready;
    assign gb_flush_o  = r_en_q && w_at_flush;
    assign part_o      = r_part;
    assign hdr_v_o     = w_ready && (r_part == '0);
    assign gb_seq_o    = r_seq;
    // Residue held in the gearbox is 2*ceil(seq/2): clear bit 0 of seq+1.
    assign gb_shift_o  = {w_seq_p1[SEQ_W-1:1], 1'b0};

    // Enable pipeline, sequence counter and block part index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en_q <= 1'b0;
            r_seq  <= '0;
            r_part <= '0;
        end else begin
            r_en_q <= en_i;
            if (!r_en_q) begin
                // Disabled lane restarts a fresh, block-aligned sequence.
                r_seq  <= '0;
                r_part <= '0;
            end else begin
                r_seq <= w_at_flush ? '0 : w_seq_p1;
                // Every ready slot consumes a beat, filled or idle.
                if (w_ready) begin
                    r_part <= (r_part == c_PART_LAST) ? '0 : r_part + 1'b1;
                end
            end
        end
    end

`ifdef PCS_TX_GB_SEQ_CHECK_EN
    logic r_err;

    // Sticky flag: MAC presented a beat while not allowed to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (beat_v_i && !w_ready) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    // Acceptance ignores beat_v_i; it only matters for the protocol check.
    logic w_unused_beat_v;
    assign w_unused_beat_v = beat_v_i;
    assign err_o           = 1'b0;
`endif

endmodule
`default_nettype wire
